// File: rtl/dest_scoreboard.sv
// dest_scoreboard: per-register pending-write counters for the general and float files,
// with issue back-pressure, writeback bypass on source lookups, flush and sticky underflow.
module dest_scoreboard #(
   parameter int REG_W   = 5,
   parameter int CNT_W   = 2,
   parameter int NUM_SRC = 3,
   parameter int NUM_WB  = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              issue_valid,
   input  logic                              issue_general,
   input  logic                              issue_float,
   input  logic [REG_W-1:0]                  issue_reg_num,
   output logic                              issue_ready,
   input  logic [NUM_SRC-1:0]                src_float,
   input  logic [NUM_SRC-1:0][REG_W-1:0]     src_reg_num,
   output logic [NUM_SRC-1:0]                src_busy,
   input  logic [NUM_WB-1:0]                 wb_valid,
   input  logic [NUM_WB-1:0]                 wb_float,
   input  logic [NUM_WB-1:0][REG_W-1:0]      wb_reg_num,
   input  logic                              flush,
   output logic                              any_pending,
   output logic                              err_underflow
);
   localparam int NREG = 2**REG_W;
   localparam int MAXC = 2**CNT_W - 1;
   logic [CNT_W-1:0] cnt_q [2][NREG];
   logic [CNT_W-1:0] cnt_d [2][NREG];
   logic err_q, err_d, uf, has_tgt;
   // General register 0 is hardwired: its writebacks never match anything.
   function automatic int hits(input logic f, input logic [REG_W-1:0] r);
      int n = 0;
      for (int j = 0; j < NUM_WB; j++)
         if (wb_valid[j] && wb_float[j] == f && wb_reg_num[j] == r && (f || r != '0)) n++;
      return n;
   endfunction
   assign has_tgt = (issue_general ^ issue_float) && (issue_float || issue_reg_num != '0);
   assign issue_ready = !(has_tgt && int'(cnt_q[issue_float][issue_reg_num]) == MAXC
                          && hits(issue_float, issue_reg_num) == 0);
   assign err_underflow = err_q;
   always_comb begin
      src_busy = '0;
      for (int i = 0; i < NUM_SRC; i++)
         src_busy[i] = int'(cnt_q[src_float[i]][src_reg_num[i]]) > hits(src_float[i], src_reg_num[i]);
   end
   always_comb begin
      any_pending = 1'b0;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < NREG; r++)
            any_pending = any_pending | (|cnt_q[f][r]);
   end
   // Issue and writebacks to one register are netted before saturating at zero.
   always_comb begin
      uf = 1'b0;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < NREG; r++) begin
            int v;
            v = int'(cnt_q[f][r]) - hits(1'(f), REG_W'(r))
              + ((issue_valid && issue_ready && has_tgt && issue_float == 1'(f)
                  && issue_reg_num == REG_W'(r)) ? 1 : 0);
            if (v < 0) uf = 1'b1;
            cnt_d[f][r] = flush ? '0 : (v < 0 ? '0 : CNT_W'(v));
         end
      err_d = err_q | (uf & ~flush);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '{default: '0};
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_dest_scoreboard.sv
// tb_dest_scoreboard: directed plus random checks of dest_scoreboard against an
// event-ordered reference model (issue first, then each writeback one at a time).
module tb_dest_scoreboard;
   logic clk = 1'b0, rst = 1'b1;
   logic iv, ig, ifl, ready, fl, anyp, err;
   logic [4:0] ir;
   logic [2:0] sf, busy;
   logic [2:0][4:0] sr;
   logic [1:0] wv, wf;
   logic [1:0][4:0] wr;
   int total = 0, bad = 0;
   int mc [2][32];
   bit merr;

   dest_scoreboard dut (
      .clk(clk), .reset(rst), .issue_valid(iv), .issue_general(ig), .issue_float(ifl),
      .issue_reg_num(ir), .issue_ready(ready), .src_float(sf), .src_reg_num(sr),
      .src_busy(busy), .wb_valid(wv), .wb_float(wf), .wb_reg_num(wr), .flush(fl),
      .any_pending(anyp), .err_underflow(err));

   always #5 clk = ~clk;

   function automatic int mhits(int f, int r);
      int n = 0;
      for (int j = 0; j < 2; j++)
         if (wv[j] && int'(wf[j]) == f && int'(wr[j]) == r && !(f == 0 && r == 0)) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      iv = 0; ig = 0; ifl = 0; ir = 0; sf = 0; sr = 0; wv = 0; wf = 0; wr = 0; fl = 0;
   endtask

   task automatic issue(input int f, input int r);
      iv = 1; ig = (f == 0); ifl = (f == 1); ir = 5'(r);
   endtask

   task automatic src(input int i, input int f, input int r);
      sf[i] = 1'(f); sr[i] = 5'(r);
   endtask

   task automatic wb(input int j, input int f, input int r);
      wv[j] = 1; wf[j] = 1'(f); wr[j] = 5'(r);
   endtask

   // One cycle: inputs are already driven; check combinational outputs, then advance the model.
   task automatic step();
      int nx [2][32];
      bit nerr, has, rdy, any;
      int e;
      #1;
      if (rst) begin mc = '{default: 0}; merr = 0; end
      has = (ig != ifl) && !(ifl == 0 && ir == 0);
      rdy = !(has && mc[ifl][ir] == 3 && mhits(int'(ifl), int'(ir)) == 0);
      chk("issue_ready", 32'(ready), 32'(rdy));
      for (int i = 0; i < 3; i++) begin
         e = (sf[i] == 0 && sr[i] == 0) ? 0 : int'(mc[sf[i]][sr[i]] > mhits(int'(sf[i]), int'(sr[i])));
         chk($sformatf("src_busy%0d", i), 32'(busy[i]), 32'(e));
      end
      any = 0;
      for (int f = 0; f < 2; f++) for (int r = 0; r < 32; r++) if (mc[f][r] != 0) any = 1;
      chk("any_pending", 32'(anyp), 32'(any));
      chk("err_underflow", 32'(err), 32'(merr));
      nx = mc; nerr = merr;
      if (fl) nx = '{default: 0};
      else begin
         if (iv && rdy && has) nx[ifl][ir]++;
         for (int j = 0; j < 2; j++)
            if (wv[j] && !(wf[j] == 0 && wr[j] == 0)) begin
               if (nx[wf[j]][wr[j]] == 0) nerr = 1;
               else nx[wf[j]][wr[j]]--;
            end
      end
      @(posedge clk);
      if (rst) begin mc = '{default: 0}; merr = 0; end
      else begin mc = nx; merr = nerr; end
      @(negedge clk);
   endtask

   initial begin
      idle();
      mc = '{default: 0}; merr = 0;
      @(negedge clk);
      step();
      rst = 0;
      // r21 issue, busy next cycle, same-cycle writeback bypass
      src(0, 0, 21); src(1, 1, 21); src(2, 0, 0);
      issue(0, 21); step();
      iv = 0; step();
      wb(0, 0, 21); step();
      wv = 0; step();
      // zero registers
      src(0, 0, 0); src(1, 1, 0); src(2, 1, 24);
      issue(0, 0); step();
      issue(1, 0); step();
      idle(); src(0, 0, 0); src(1, 1, 0); src(2, 1, 24);
      wb(0, 0, 0); step();
      wv = 0; step();
      wb(1, 1, 0); step();
      wv = 0;
      // float r24 saturation and back-pressure relief by writeback
      for (int k = 0; k < 4; k++) begin issue(1, 24); step(); end
      issue(1, 24); wb(1, 1, 24); step();
      idle(); src(2, 1, 24);
      for (int k = 0; k < 3; k++) begin wb(0, 1, 24); step(); wv = 0; step(); end
      // general r6 issue + writeback same cycle
      src(0, 0, 6);
      issue(0, 6); step();
      issue(0, 6); wb(0, 0, 6); step();
      idle(); src(0, 0, 6); step();
      wb(1, 0, 6); step();
      // double writeback underflow on r8
      idle(); src(0, 0, 8);
      issue(0, 8); step();
      iv = 0; wb(0, 0, 8); wb(1, 0, 8); step();
      wv = 0; step(); step();
      // flush with concurrent issue
      idle(); src(0, 0, 5); src(1, 0, 7); src(2, 1, 3);
      issue(0, 5); step();
      issue(0, 7); step();
      issue(1, 3); step();
      issue(0, 9); fl = 1; step();
      idle(); src(0, 0, 9); src(1, 0, 5); src(2, 1, 3); step();
      // asynchronous reset mid-sequence
      issue(0, 5); step();
      issue(1, 3); wb(0, 0, 31); step();
      idle(); src(0, 0, 5); src(1, 1, 3);
      rst = 1;
      #1;
      chk("async_any_pending", 32'(anyp), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_ready", 32'(ready), 32'd1);
      chk("async_err", 32'(err), 32'd0);
      step();
      rst = 0;
      // random traffic on a small register window so collisions are frequent
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 149) == 0);
         iv = ($urandom_range(0, 9) < 6); ig = 1'($urandom); ifl = 1'($urandom);
         ir = 5'($urandom_range(0, 3));
         for (int i = 0; i < 3; i++) src(i, $urandom_range(0, 1), $urandom_range(0, 3));
         for (int j = 0; j < 2; j++) begin
            wv[j] = ($urandom_range(0, 9) < 3); wf[j] = 1'($urandom); wr[j] = 5'($urandom_range(0, 3));
         end
         fl = ($urandom_range(0, 29) == 0);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
